// File: rtl/fwd_pkg.sv
// Shared types, constants and the packed-field helper for the forwarding/hazard controller.
package fwd_pkg;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } fwd_state_e;

    localparam int unsigned SEL_REGFILE = 0;
    localparam int unsigned FIELD_MAX_W = 16;
    localparam int unsigned VEC_MAX_W   = 256;

    // Returns field idx (width w) of a zero-extended packed vector; caller truncates to w bits.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [VEC_MAX_W-1:0]   shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = FIELD_MAX_W'((32'd1 << w) - 32'd1);
        return shifted[FIELD_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Forwarding select for one EXE source operand: priority encoder over the later stages.
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned NO_FWD_REG = 15
) (
    input  logic [REG_AW-1:0]         i_src,
    input  logic [NUM_FWD*REG_AW-1:0] i_fwd_dest,
    input  logic [NUM_FWD-1:0]        i_fwd_wb_enb,
    output logic [SEL_W-1:0]          o_sel
);

    logic w_src_ok;

    assign w_src_ok = (32'(i_src) != NO_FWD_REG);

    // Scan from the farthest stage down so the nearest matching stage overrides.
    always_comb begin
        o_sel = SEL_W'(SEL_REGFILE);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (w_src_ok && i_fwd_wb_enb[k] &&
                i_src == REG_AW'(get_field(VEC_MAX_W'(i_fwd_dest), k, REG_AW))) begin
                o_sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, RAW/load-use hazard stall, SRAM freeze and saturating perf counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned NUM_FWD      = 2,
    parameter int unsigned SEL_W        = $clog2(NUM_FWD + 1),
    parameter int unsigned NO_FWD_REG   = 15,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       forward_enb,
    input  logic [NUM_SRC*REG_AW-1:0]  src_id,
    input  logic [NUM_SRC-1:0]         src_vld_id,
    input  logic [NUM_SRC*REG_AW-1:0]  src_exe,
    input  logic [REG_AW-1:0]          dest_exe,
    input  logic                       wb_enb_exe,
    input  logic                       mem_r_exe,
    input  logic [NUM_FWD*REG_AW-1:0]  fwd_dest,
    input  logic [NUM_FWD-1:0]         fwd_wb_enb,
    input  logic                       mem_req_mem,
    input  logic                       sram_ready,
    input  logic                       cnt_clr,
    output logic [NUM_SRC*SEL_W-1:0]   sel_src,
    output logic                       hazard_stall,
    output logic                       pipe_freeze,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           freeze_cnt
);

    fwd_state_e               r_state;
    fwd_state_e               w_state_nxt;
    logic [3:0]               r_bub_cnt;
    logic [3:0]               w_bub_nxt;
    logic [CNT_W-1:0]         r_stall_cnt;
    logic [CNT_W-1:0]         r_freeze_cnt;
    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic [REG_AW-1:0]        w_src_id;
    logic                     w_freeze;
    logic                     w_detect;
    logic                     w_stall;

    function automatic logic match(
        input logic [REG_AW-1:0] s,
        input logic [REG_AW-1:0] d,
        input logic              en
    );
        return en && (s == d) && (32'(s) != NO_FWD_REG);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] w_src_exe;

            assign w_src_exe = REG_AW'(get_field(VEC_MAX_W'(src_exe), gi, REG_AW));

            fwd_src_select #(
                .REG_AW     (REG_AW),
                .NUM_FWD    (NUM_FWD),
                .SEL_W      (SEL_W),
                .NO_FWD_REG (NO_FWD_REG)
            ) u_src_select (
                .i_src        (w_src_exe),
                .i_fwd_dest   (fwd_dest),
                .i_fwd_wb_enb (fwd_wb_enb),
                .o_sel        (w_sel[gi*SEL_W +: SEL_W])
            );
        end
    endgenerate

    assign w_freeze = mem_req_mem && !sram_ready;

    // Without forwarding the last stage is safe: it writes the register file before the read.
    always_comb begin
        w_detect = 1'b0;
        w_src_id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src_id = REG_AW'(get_field(VEC_MAX_W'(src_id), i, REG_AW));
            if (src_vld_id[i]) begin
                if (forward_enb) begin
                    if (match(w_src_id, dest_exe, wb_enb_exe && mem_r_exe)) begin
                        w_detect = 1'b1;
                    end
                end else begin
                    if (match(w_src_id, dest_exe, wb_enb_exe)) begin
                        w_detect = 1'b1;
                    end
                    for (int k = 0; k < NUM_FWD - 1; k++) begin
                        if (match(w_src_id, REG_AW'(get_field(VEC_MAX_W'(fwd_dest), k, REG_AW)),
                                  fwd_wb_enb[k])) begin
                            w_detect = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub_cnt;
        if (!w_freeze) begin
            case (r_state)
                RUN: begin
                    if (w_detect && forward_enb && (LOAD_BUBBLES > 1)) begin
                        w_state_nxt = LOAD_STALL;
                        w_bub_nxt   = 4'(LOAD_BUBBLES - 1);
                    end
                end
                LOAD_STALL: begin
                    w_bub_nxt = r_bub_cnt - 4'd1;
                    if (r_bub_cnt == 4'd1) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign w_stall = (r_state == LOAD_STALL) || w_detect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_bub_cnt    <= '0;
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bub_cnt <= w_bub_nxt;
            if (cnt_clr) begin
                r_stall_cnt  <= '0;
                r_freeze_cnt <= '0;
            end else begin
                if (w_stall && !w_freeze && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if (w_freeze && (r_freeze_cnt != '1)) begin
                    r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sel_src      = (rst_n && forward_enb) ? w_sel : '0;
    assign hazard_stall = rst_n && w_stall;
    assign pipe_freeze  = rst_n && w_freeze;
    assign stall_cnt    = r_stall_cnt;
    assign freeze_cnt   = r_freeze_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl (LOAD_BUBBLES=2, CNT_W=2 to reach counter saturation).
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       forward_enb;
    logic [7:0] src_id;
    logic [1:0] src_vld_id;
    logic [7:0] src_exe;
    logic [3:0] dest_exe;
    logic       wb_enb_exe;
    logic       mem_r_exe;
    logic [7:0] fwd_dest;
    logic [1:0] fwd_wb_enb;
    logic       mem_req_mem;
    logic       sram_ready;
    logic       cnt_clr;
    logic [3:0] sel_src;
    logic       hazard_stall;
    logic       pipe_freeze;
    logic [1:0] stall_cnt;
    logic [1:0] freeze_cnt;

    // Observation: {stall_cnt, freeze_cnt, sel1, sel0, hazard_stall, pipe_freeze}
    logic [9:0] obs;
    assign obs = {stall_cnt, freeze_cnt, sel_src, hazard_stall, pipe_freeze};

    typedef struct {
        string      name;
        logic [9:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_chk;
    int unsigned n_pass;
    logic [1:0]  m_scnt;
    logic [1:0]  m_fcnt;

    fwd_hazard_ctrl #(
        .REG_AW       (4),
        .NUM_SRC      (2),
        .NUM_FWD      (2),
        .SEL_W        (2),
        .NO_FWD_REG   (15),
        .LOAD_BUBBLES (2),
        .CNT_W        (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .forward_enb  (forward_enb),
        .src_id       (src_id),
        .src_vld_id   (src_vld_id),
        .src_exe      (src_exe),
        .dest_exe     (dest_exe),
        .wb_enb_exe   (wb_enb_exe),
        .mem_r_exe    (mem_r_exe),
        .fwd_dest     (fwd_dest),
        .fwd_wb_enb   (fwd_wb_enb),
        .mem_req_mem  (mem_req_mem),
        .sram_ready   (sram_ready),
        .cnt_clr      (cnt_clr),
        .sel_src      (sel_src),
        .hazard_stall (hazard_stall),
        .pipe_freeze  (pipe_freeze),
        .stall_cnt    (stall_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        rst_n       = 1'b1;
        forward_enb = 1'b1;
        src_id      = '0;
        src_vld_id  = '0;
        src_exe     = '0;
        dest_exe    = '0;
        wb_enb_exe  = 1'b0;
        mem_r_exe   = 1'b0;
        fwd_dest    = '0;
        fwd_wb_enb  = '0;
        mem_req_mem = 1'b0;
        sram_ready  = 1'b1;
        cnt_clr     = 1'b0;
    endtask

    // Load with dest 5 in EXE, ID source 0 reads r5.
    task automatic drive_load_hazard();
        dest_exe   = 4'd5;
        wb_enb_exe = 1'b1;
        mem_r_exe  = 1'b1;
        src_id     = {4'd0, 4'd5};
        src_vld_id = 2'b01;
    endtask

    // Counter model advanced at each clock edge from the expected stall/freeze of that cycle.
    task automatic model_edge(input logic [5:0] ex);
        if (!rst_n || cnt_clr) begin
            m_scnt = 2'd0;
            m_fcnt = 2'd0;
        end else begin
            if (ex[1] && !ex[0] && m_scnt != 2'd3) m_scnt = m_scnt + 2'd1;
            if (ex[0] && m_fcnt != 2'd3) m_fcnt = m_fcnt + 2'd1;
        end
    endtask

    task automatic test_reset();
        exp_t       e;
        logic [5:0] tab [3];
        tab = '{6'b00_00_00, 6'b00_00_00, 6'b00_00_00};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_idle();
            if (c < 2) begin
                rst_n       = 1'b0;
                src_exe     = {4'd0, 4'd3};
                fwd_dest    = {4'd0, 4'd3};
                fwd_wb_enb  = 2'b01;
                mem_req_mem = 1'b1;
                sram_ready  = 1'b0;
                drive_load_hazard();
            end
            exp_q.push_back('{name: $sformatf("reset_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_fwd_select();
        exp_t       e;
        logic [5:0] tab [4];
        tab = '{6'b00_01_00, 6'b00_10_00, 6'b00_10_00, 6'b00_00_00};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_idle();
            case (c)
                0: begin
                    src_exe = {4'd0, 4'd3}; fwd_dest = {4'd3, 4'd3}; fwd_wb_enb = 2'b11;
                end
                1: begin
                    src_exe = {4'd0, 4'd3}; fwd_dest = {4'd3, 4'd3}; fwd_wb_enb = 2'b10;
                end
                default: begin
                    forward_enb = (c == 2);
                    src_exe     = {4'd15, 4'd3};
                    fwd_dest    = {4'd3, 4'd15};
                    fwd_wb_enb  = 2'b11;
                    src_id      = {4'd15, 4'd0};
                    src_vld_id  = 2'b10;
                    dest_exe    = 4'd15;
                    wb_enb_exe  = 1'b1;
                    mem_r_exe   = 1'b1;
                end
            endcase
            exp_q.push_back('{name: $sformatf("fwdsel_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_load_use();
        exp_t       e;
        logic [5:0] tab [4];
        tab = '{6'b00_00_00, 6'b00_00_10, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) cnt_clr = 1'b1;
            if (c == 1) drive_load_hazard();
            exp_q.push_back('{name: $sformatf("loaduse_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_hazard_modes();
        exp_t       e;
        logic [5:0] tab [5];
        tab = '{6'b00_00_00, 6'b00_00_10, 6'b00_00_00, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_idle();
            case (c)
                0: begin
                    drive_load_hazard();
                    src_vld_id = 2'b00;
                end
                1: begin
                    forward_enb = 1'b0;
                    fwd_dest = {4'd0, 4'd7}; fwd_wb_enb = 2'b01;
                    src_id = {4'd0, 4'd7}; src_vld_id = 2'b01; src_exe = {4'd0, 4'd7};
                end
                2: begin
                    forward_enb = 1'b0;
                    fwd_dest = {4'd7, 4'd0}; fwd_wb_enb = 2'b10;
                    src_id = {4'd0, 4'd7}; src_vld_id = 2'b01;
                end
                default: begin
                    forward_enb = (c == 4);
                    dest_exe = 4'd7; wb_enb_exe = 1'b1;
                    src_id = {4'd0, 4'd7}; src_vld_id = 2'b01;
                end
            endcase
            exp_q.push_back('{name: $sformatf("modes_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_freeze_stall();
        exp_t       e;
        logic [5:0] tab [7];
        tab = '{6'b00_00_00, 6'b00_00_10, 6'b00_00_11, 6'b00_01_11,
                6'b00_00_11, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) cnt_clr = 1'b1;
            if (c == 1) drive_load_hazard();
            if (c >= 2 && c <= 4) begin
                mem_req_mem = 1'b1;
                sram_ready  = 1'b0;
            end
            if (c == 3) begin
                src_exe = {4'd0, 4'd3}; fwd_dest = {4'd0, 4'd3}; fwd_wb_enb = 2'b01;
            end
            exp_q.push_back('{name: $sformatf("frzstall_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_freeze_detect();
        exp_t       e;
        logic [5:0] tab [5];
        tab = '{6'b00_00_00, 6'b00_00_11, 6'b00_00_10, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) cnt_clr = 1'b1;
            if (c == 1 || c == 2) drive_load_hazard();
            if (c == 1) begin
                mem_req_mem = 1'b1;
                sram_ready  = 1'b0;
            end
            exp_q.push_back('{name: $sformatf("frzdet_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_fwd_drop();
        exp_t       e;
        logic [5:0] tab [3];
        tab = '{6'b00_00_10, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) drive_load_hazard();
            else forward_enb = 1'b0;
            exp_q.push_back('{name: $sformatf("fwddrop_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_saturate();
        exp_t       e;
        logic [5:0] tab [9];
        tab = '{6'b00_00_00, 6'b00_00_10, 6'b00_00_10, 6'b00_00_10, 6'b00_00_10,
                6'b00_00_10, 6'b00_00_00, 6'b00_00_10, 6'b00_00_00};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0 || c == 7) cnt_clr = 1'b1;
            if ((c >= 1 && c <= 5) || c == 7) begin
                forward_enb = 1'b0;
                fwd_dest = {4'd0, 4'd7}; fwd_wb_enb = 2'b01;
                src_id = {4'd0, 4'd7}; src_vld_id = 2'b01;
            end
            exp_q.push_back('{name: $sformatf("saturate_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t       e;
        logic [5:0] tab [4];
        tab = '{6'b00_00_10, 6'b00_00_00, 6'b00_00_00, 6'b00_00_00};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_idle();
            if (c == 0) drive_load_hazard();
            if (c == 1) begin
                rst_n       = 1'b0;
                mem_req_mem = 1'b1;
                sram_ready  = 1'b0;
                src_exe = {4'd0, 4'd3}; fwd_dest = {4'd0, 4'd3}; fwd_wb_enb = 2'b01;
            end
            exp_q.push_back('{name: $sformatf("rstmid_c%0d", c), val: {m_scnt, m_fcnt, tab[c]}});
            #1;
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e.val) $display("FAIL %s: got %b required %b", e.name, obs, e.val);
            else n_pass++;
            model_edge(tab[c]);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_scnt = 2'd0;
        m_fcnt = 2'd0;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        test_reset();
        test_fwd_select();
        test_load_use();
        test_hazard_modes();
        test_freeze_stall();
        test_freeze_detect();
        test_fwd_drop();
        test_saturate();
        test_reset_mid_stall();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
